// File: rtl/button_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : button_input_ctrl
// Brief   : N-channel button front end: 2-flop sync, debounce, press/release
//           pulses, per-button auto-repeat (BUTTON_AUTOREPEAT_EN) and an
//           all-buttons chord pulse.
// Rev     : 1.0  initial release
// ============================================================================
module button_input_ctrl #(
    parameter int NUM_BUTTONS    = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000,
    parameter int CHORD_HOLD     = 25000000
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [NUM_BUTTONS-1:0] i_Buttons,
    output logic [NUM_BUTTONS-1:0] o_Debounced,
    output logic [NUM_BUTTONS-1:0] o_Press,
    output logic [NUM_BUTTONS-1:0] o_Release,
    output logic [NUM_BUTTONS-1:0] o_Repeat,
    output logic                   o_Chord
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT);
    localparam int CH_W = $clog2(CHORD_HOLD);

    if (NUM_BUTTONS < 1 || NUM_BUTTONS > 8 || DEBOUNCE_LIMIT < 2 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || CHORD_HOLD < 2) begin : g_param_check
        $error("button_input_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        CH_ARMED = 2'd0,
        CH_COUNT = 2'd1,
        CH_FIRED = 2'd2
    } chord_state_t;

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] deb_q, deb_d;
    logic [NUM_BUTTONS-1:0] press_q, release_q;
    logic [NUM_BUTTONS-1:0] deb_rise, deb_fall;

    chord_state_t           chord_state_q, chord_state_d;
    logic [CH_W-1:0]        chord_cnt_q, chord_cnt_d;
    logic                   chord_q, chord_d;
    logic                   all_held_d;

    assign deb_rise   = deb_d & ~deb_q;
    assign deb_fall   = ~deb_d & deb_q;
    assign all_held_d = &deb_d;

    // Per-channel debounce: accept a new level after DEBOUNCE_LIMIT
    // consecutive synced samples that disagree with the current level.
    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
        logic [DB_W-1:0] db_cnt_q, db_cnt_d;
        logic            deb_bit_d;

        always_comb begin
            db_cnt_d  = '0;
            deb_bit_d = deb_q[g];
            if (sync2_q[g] != deb_q[g]) begin
                if (db_cnt_q == DB_W'(DEBOUNCE_LIMIT - 1)) begin
                    deb_bit_d = sync2_q[g];
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
        end

        assign deb_d[g] = deb_bit_d;

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_d;
            end
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX);

    typedef enum logic [1:0] {
        RP_IDLE  = 2'd0,
        RP_DELAY = 2'd1,
        RP_RPT   = 2'd2
    } rpt_state_t;

    logic [NUM_BUTTONS-1:0] repeat_q, rpt_pulse_d;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_rpt
        rpt_state_t       rpt_state_q, rpt_state_d;
        logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
        logic             pulse_d;

        always_comb begin
            rpt_state_d = rpt_state_q;
            rpt_cnt_d   = '0;
            pulse_d     = 1'b0;
            if (deb_fall[g]) begin
                rpt_state_d = RP_IDLE;
            end else begin
                case (rpt_state_q)
                    RP_IDLE: begin
                        if (deb_rise[g]) begin
                            rpt_state_d = RP_DELAY;
                            pulse_d     = 1'b1;
                        end
                    end
                    RP_DELAY: begin
                        if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
                            rpt_state_d = RP_RPT;
                            pulse_d     = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    RP_RPT: begin
                        if (rpt_cnt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
                            pulse_d = 1'b1;
                        end else begin
                            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                        end
                    end
                    default: rpt_state_d = RP_IDLE;
                endcase
            end
        end

        assign rpt_pulse_d[g] = pulse_d;

        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                rpt_state_q <= RP_IDLE;
                rpt_cnt_q   <= '0;
            end else begin
                rpt_state_q <= rpt_state_d;
                rpt_cnt_q   <= rpt_cnt_d;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            repeat_q <= '0;
        end else begin
            repeat_q <= rpt_pulse_d;
        end
    end

    assign o_Repeat = repeat_q;
`else
    assign o_Repeat = press_q;
`endif

    // Chord tracks the next-state debounced vector so the count starts on the
    // same edge the last button's debounced level rises.
    always_comb begin
        chord_state_d = chord_state_q;
        chord_cnt_d   = '0;
        chord_d       = 1'b0;
        case (chord_state_q)
            CH_ARMED: begin
                if (all_held_d) chord_state_d = CH_COUNT;
            end
            CH_COUNT: begin
                if (!all_held_d) begin
                    chord_state_d = CH_ARMED;
                end else if (chord_cnt_q == CH_W'(CHORD_HOLD - 1)) begin
                    chord_state_d = CH_FIRED;
                    chord_d       = 1'b1;
                end else begin
                    chord_cnt_d = chord_cnt_q + CH_W'(1);
                end
            end
            CH_FIRED: begin
                if (!all_held_d) chord_state_d = CH_ARMED;
            end
            default: chord_state_d = CH_ARMED;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            deb_q         <= '0;
            press_q       <= '0;
            release_q     <= '0;
            chord_state_q <= CH_ARMED;
            chord_cnt_q   <= '0;
            chord_q       <= 1'b0;
        end else begin
            sync1_q       <= i_Buttons;
            sync2_q       <= sync1_q;
            deb_q         <= deb_d;
            press_q       <= deb_rise;
            release_q     <= deb_fall;
            chord_state_q <= chord_state_d;
            chord_cnt_q   <= chord_cnt_d;
            chord_q       <= chord_d;
        end
    end

    assign o_Debounced = deb_q;
    assign o_Press     = press_q;
    assign o_Release   = release_q;
    assign o_Chord     = chord_q;

endmodule
`default_nettype wire

// File: tb/tb_button_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_input_ctrl
// Brief   : Self-checking bench for button_input_ctrl against a window/event
//           reference model; directed scenarios followed by random holds.
// Rev     : 1.0  initial release
// ============================================================================
module tb_button_input_ctrl;

    localparam int NB = 4;
    localparam int DL = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [NB-1:0] btn;
    logic [NB-1:0] o_Debounced, o_Press, o_Release, o_Repeat;
    logic          o_Chord;

    always #5 clk = ~clk;

    button_input_ctrl #(
        .NUM_BUTTONS   (NB),
        .DEBOUNCE_LIMIT(DL),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP),
        .CHORD_HOLD    (CH)
    ) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Buttons  (btn),
        .o_Debounced(o_Debounced),
        .o_Press    (o_Press),
        .o_Release  (o_Release),
        .o_Repeat   (o_Repeat),
        .o_Chord    (o_Chord)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: raw level seen at each post-reset edge.
    logic [NB-1:0] raw_q[$];
    int            ed;
    logic [NB-1:0] m_deb;
    int            press_edge[NB];
    int            all_edge;

    // Observed tallies for directed scenario checks.
    int obs_rep0, obs_press0, obs_rel0, obs_chord, obs_press1, obs_rel1, obs_deb1;
    int press0_edge, press2_edge, chord_edge;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ed, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs == exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Synced sample used at edge idx+2; everything before reset release is 0.
    function automatic logic smp(int ch, int idx);
        if (idx < 0) return 1'b0;
        return raw_q[idx][ch];
    endfunction

    task automatic tick(input logic [NB-1:0] b);
        logic [NB-1:0] nd, ex_press, ex_rel, ex_rep;
        logic          ex_chord;
        int            d;
        bit            stable;
        btn = b;
        @(posedge clk);
        raw_q.push_back(b);
        nd = m_deb;
        for (int c = 0; c < NB; c++) begin
            stable = 1'b1;
            for (int j = 0; j < DL; j++) begin
                if (smp(c, ed - 2 - j) == m_deb[c]) stable = 1'b0;
            end
            if (stable) nd[c] = ~m_deb[c];
        end
        ex_press = nd & ~m_deb;
        ex_rel   = ~nd & m_deb;
        for (int c = 0; c < NB; c++) begin
            if (ex_press[c]) press_edge[c] = ed;
        end
`ifdef BUTTON_AUTOREPEAT_EN
        for (int c = 0; c < NB; c++) begin
            d = ed - press_edge[c];
            ex_rep[c] = nd[c] && (d == 0 || d == RD || (d > RD && ((d - RD) % RP) == 0));
        end
`else
        ex_rep = ex_press;
`endif
        if ((&nd) && !(&m_deb)) all_edge = ed;
        ex_chord = (&nd) && (ed - all_edge == CH);
        m_deb = nd;

        @(negedge clk);
        chk("debounced", o_Debounced, nd);
        chk("press", o_Press, ex_press);
        chk("release", o_Release, ex_rel);
        chk("repeat", o_Repeat, ex_rep);
        chk("chord", {{(NB-1){1'b0}}, o_Chord}, {{(NB-1){1'b0}}, ex_chord});

        obs_rep0   += int'(o_Repeat[0]);
        obs_press0 += int'(o_Press[0]);
        obs_rel0   += int'(o_Release[0]);
        obs_press1 += int'(o_Press[1]);
        obs_rel1   += int'(o_Release[1]);
        obs_deb1   += int'(o_Debounced[1]);
        obs_chord  += int'(o_Chord);
        if (o_Press[0]) press0_edge = ed;
        if (o_Press[2]) press2_edge = ed;
        if (o_Chord)    chord_edge  = ed;
        ed++;
    endtask

    // Asserts reset between clock edges, checks the asynchronous clear, then
    // releases on a falling edge so the next rising edge is post-reset edge 0.
    task automatic do_reset(input logic [NB-1:0] hold);
        rst_l = 1'b0;
        btn   = hold;
        #1;
        chk("rst_debounced", o_Debounced, '0);
        chk("rst_press", o_Press, '0);
        chk("rst_release", o_Release, '0);
        chk("rst_repeat", o_Repeat, '0);
        chk("rst_chord", {{(NB-1){1'b0}}, o_Chord}, '0);
        repeat (2) @(negedge clk);
        raw_q.delete();
        ed       = 0;
        m_deb    = '0;
        all_edge = -1000;
        for (int c = 0; c < NB; c++) press_edge[c] = 0;
        obs_rep0 = 0; obs_press0 = 0; obs_rel0 = 0; obs_chord = 0;
        obs_press1 = 0; obs_rel1 = 0; obs_deb1 = 0;
        press0_edge = -1; press2_edge = -1; chord_edge = -1;
        rst_l = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_l = 1'b1;
        btn   = '0;
        @(negedge clk);

        // Clean press held 40 cycles, then released.
        do_reset('0);
        repeat (40) tick(4'b0001);
        chk_int("press0_edge", press0_edge, 5);
        chk_int("press0_count", obs_press0, 1);
        repeat (12) tick(4'b0000);
`ifdef BUTTON_AUTOREPEAT_EN
        chk_int("repeat0_count", obs_rep0, 11);
`else
        chk_int("repeat0_count", obs_rep0, 1);
`endif
        chk_int("release0_count", obs_rel0, 1);

        // Bounce on button 1: 3-cycle toggles never settle.
        do_reset('0);
        for (int i = 0; i < 10; i++) begin
            repeat (3) tick((i % 2 == 0) ? 4'b0010 : 4'b0000);
        end
        repeat (12) tick(4'b0000);
        chk_int("bounce_deb1", obs_deb1, 0);
        chk_int("bounce_press1", obs_press1, 0);
        chk_int("bounce_rel1", obs_rel1, 0);

        // Chord: all held, then button 2 released and re-pressed.
        do_reset('0);
        repeat (30) tick(4'b1111);
        chk_int("chord_edge", chord_edge, 13);
        chk_int("chord_count1", obs_chord, 1);
        repeat (10) tick(4'b1011);
        repeat (20) tick(4'b1111);
        chk_int("chord_count2", obs_chord, 2);
        chk_int("chord_after_press2", chord_edge - press2_edge, CH);

        // Reset while button 0 is in steady repeat, still held at release.
        do_reset('0);
        repeat (25) tick(4'b0001);
        do_reset(4'b0001);
        repeat (10) tick(4'b0001);
        chk_int("post_reset_press0_edge", press0_edge, 5);

        // Random held patterns of random length.
        do_reset('0);
        for (int s = 0; s < 40; s++) begin
            logic [NB-1:0] pat;
            int            len;
            pat = NB'($urandom_range(0, (1 << NB) - 1));
            len = $urandom_range(1, 20);
            repeat (len) tick(pat);
        end
        repeat (12) tick(4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_input_ctrl.md
# button_input_ctrl

Parametrised front-panel input controller that replaces the fixed four-switch debouncer feeding the game core. It takes N raw, asynchronous button lines and produces, per button, a debounced level, one-cycle press and release pulses, and an auto-repeat pulse train for held buttons. It also produces a hold-all-buttons "chord" pulse, which is used as the game-start/reset request. It sits between the board switch pins and the game logic, in the pixel clock domain.

## Interface
Parameters:
- NUM_BUTTONS, 4, number of button channels (1..8)
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required to accept a new level (≥2; 10 ms at 25 MHz)
- REPEAT_DELAY, 12500000, cycles from press pulse to first repeat pulse (≥2)
- REPEAT_PERIOD, 2500000, cycles between subsequent repeat pulses (≥2)
- CHORD_HOLD, 25000000, cycles all buttons must be held before the chord pulse fires (≥2)

Ports:
- i_Clk  in  1  system/pixel clock; the only clock
- i_Rst_L  in  1  asynchronous, active-low reset
- i_Buttons  in  NUM_BUTTONS  raw button levels, 1 = pressed, asynchronous
- o_Debounced  out  NUM_BUTTONS  debounced level per button
- o_Press  out  NUM_BUTTONS  one-cycle pulse on each debounced 0→1
- o_Release  out  NUM_BUTTONS  one-cycle pulse on each debounced 1→0
- o_Repeat  out  NUM_BUTTONS  one-cycle pulse on press, then auto-repeat while held
- o_Chord  out  1  one-cycle pulse after all buttons are held CHORD_HOLD cycles

## Operation
- Reset: all outputs 0; synchronisers, debounced state, counters and FSMs cleared. Reset is asserted asynchronously and released on the clock.
- Synchroniser: a 2-flop stage per channel on i_Buttons. Nothing downstream sees the raw input.
- Debounce, per channel:
  - Counter width is $clog2(DEBOUNCE_LIMIT).
  - If the synced level equals o_Debounced, the counter clears.
  - Otherwise the counter increments. On the cycle where it reaches DEBOUNCE_LIMIT-1, o_Debounced takes the synced level and the counter clears.
  - Any glitch back to the old level restarts the count from 0.
- Edge pulses:
  - o_Press[i] is high exactly during the first cycle o_Debounced[i] is 1.
  - o_Release[i] is high exactly during the first cycle o_Debounced[i] is 0.
  - No pulses are generated out of reset.
- Repeat FSM, per channel. States are IDLE, DELAY and RPT.
  - IDLE→DELAY on press. o_Repeat[i] pulses in the same cycle as o_Press[i].
  - DELAY: counts REPEAT_DELAY cycles, then pulses o_Repeat and moves to RPT.
  - RPT: pulses every REPEAT_PERIOD cycles.
  - Debounced release in any state → IDLE that cycle and clears the counter. No pulse is emitted in the release cycle.
- Chord FSM. States are ARMED, COUNT and FIRED.
  - ARMED→COUNT when all o_Debounced bits are 1.
  - COUNT: after CHORD_HOLD cycles with all bits 1, o_Chord pulses for one cycle → FIRED. Any bit dropping returns to ARMED with the counter cleared.
  - FIRED: stays until any bit drops, then ARMED. There is exactly one chord pulse per hold.
- Channels are independent. Simultaneous presses on several channels produce simultaneous pulses.

## Timing
- Latency: the raw level is first sampled at edge k, and the input is then held stable. o_Debounced changes after edge k+DEBOUNCE_LIMIT+1, so it is visible from cycle k+DEBOUNCE_LIMIT+2.
- o_Press, o_Release and the first o_Repeat are coincident with that o_Debounced change.
- Repeat pulses fall at press cycle P, then P+REPEAT_DELAY, then P+REPEAT_DELAY+n·REPEAT_PERIOD.
- o_Chord fires CHORD_HOLD cycles after the cycle in which the last button's o_Debounced rose.
- All outputs are registered. There are no combinational paths from i_Buttons.
- Reset mid-operation: outputs drop to 0 immediately. A button still held at reset release is debounced afresh and yields a new press after the full latency.

## Configuration
- BUTTON_AUTOREPEAT_EN defined: the repeat FSMs and counters are built as described above.
- BUTTON_AUTOREPEAT_EN undefined: the repeat logic is not instantiated and o_Repeat equals o_Press (the registered copy, identical timing). REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
All scenarios use NUM_BUTTONS=4, DEBOUNCE_LIMIT=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, CHORD_HOLD=8, with i_Buttons[0] rising before edge 0.

- Clean press: hold i_Buttons[0]=1 → o_Debounced[0], o_Press[0] and o_Repeat[0] all rise in cycle 6. o_Press[0] is high for 1 cycle only.
- Bounce: toggle i_Buttons[1] every 3 cycles for 30 cycles, then hold at 0 → o_Debounced[1], o_Press[1] and o_Release[1] stay 0 throughout.
- Auto-repeat (macro defined): hold button 0 for 40 cycles → o_Repeat[0] pulses in cycles 6, 16, 19, 22, 25 and so on. After release, o_Release[0] pulses once and no further o_Repeat pulses occur.
- Macro undefined, same stimulus → a single o_Repeat[0] pulse in cycle 6.
- Chord: press all four buttons together and hold for 30 cycles → one o_Chord pulse in cycle 14. Release button 2, re-press it and hold → exactly one more chord pulse, 8 cycles after o_Debounced[2] rises again.
- Reset mid-hold: drive i_Rst_L=0 during repeat state RPT → all outputs 0 asynchronously. Release reset with the button still held → a new o_Press 6 cycles after the first post-reset edge.
